bcd_bin: RTL and testbench

- Sequential signed BCD-to-binary converter; inverse of the team's sign + three-digit BCD display encoder.
- Accepts sign plus hundreds/tens/units BCD digits, e.g. from the keypad/operand-entry path.
- Produces an 8-bit two's-complement value for the processor datapath.
- Uses the reverse double-dabble algorithm, one shift-correct step per clock, with a start/busy/done handshake.

---
 rtl/bcd_bin_pkg.sv | 28 ++
 rtl/bcd_bin_digit_corr.sv | 14 +
 rtl/bcd_bin.sv | 136 +++++++++++++
 tb/tb_bcd_bin.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_bin_pkg.sv
// Shared definitions for the signed BCD-to-binary converter.
// Holds the FSM state encoding, the algorithm sizing constants, the
// saturation limits and a small helper that flags non-decimal digits.
package bcd_bin_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CONV   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam int N_DIGITS    = 3;
    localparam int N_ITER      = 10;
    localparam int MAG_MAX_POS = 127;
    localparam int MAG_MAX_NEG = 128;
    localparam int DIGIT_MAX   = 9;

    // True when any packed BCD digit is outside 0..9.
    function automatic logic bcd_invalid(input logic [4*N_DIGITS-1:0] bcd);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (bcd[4*i +: 4] > 4'(DIGIT_MAX)) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_bin_digit_corr.sv
// Reverse double-dabble digit correction.
// After a right shift, a BCD digit that reads 8 or more carried in a bit
// worth 5 decimal but 8 binary, so 3 is taken off to restore its value.
// Ports:
//   digit     - shifted 4-bit BCD digit
//   corrected - digit after correction (4-bit unsigned arithmetic)
module bcd_digit_corr (
    input  logic [3:0] digit,
    output logic [3:0] corrected
);

    assign corrected = (digit >= 4'd8) ? (digit - 4'd3) : digit;

endmodule

// File: rtl/bcd_bin.sv
// Sequential signed BCD-to-binary converter.
// Takes a sign plus hundreds/tens/units BCD digits and produces an 8-bit
// two's-complement value using reverse double-dabble, one shift-correct
// step per clock, with saturation and an error flag for out-of-range or
// non-decimal operands.
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   start    - conversion request, sampled only while idle
//   negative - operand sign (1 = negative)
//   centena  - hundreds BCD digit
//   dezena   - tens BCD digit
//   unidade  - units BCD digit
//   out      - two's-complement result, held until the next done
//   busy     - conversion in progress
//   done     - one-cycle pulse, out/error valid from this cycle
//   error    - result status, held with out
//
// state    | meaning
// ---------+-------------------------------------------------------
// S_IDLE   | waiting for start; operands captured on the start edge
// S_CONV   | one shift-correct iteration per clock, N_ITER in total
// S_FINISH | range check, sign apply, done pulse, back to idle
module bcd_bin
    import bcd_bin_pkg::*;
#(
    parameter int N_ITER = bcd_bin_pkg::N_ITER
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       negative,
    input  logic [3:0] centena,
    input  logic [3:0] dezena,
    input  logic [3:0] unidade,
    output logic [7:0] out,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam logic [3:0] LAST_ITER = 4'(N_ITER - 1);

    logic [1:0]  state;
    logic [11:0] bcd_q;
    logic [9:0]  mag_q;
    logic [3:0]  cnt_q;
    logic        neg_q;
    logic        inv_q;

    logic [21:0] shifted;
    logic [11:0] bcd_corr;
    logic [7:0]  res_out;
    logic        res_err;

    // BCD and magnitude shift as one register: the BCD LSB feeds the
    // magnitude MSB.
    assign shifted = {bcd_q, mag_q} >> 1;

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_corr
        bcd_digit_corr u_corr (
            .digit    (shifted[10 + 4*g +: 4]),
            .corrected(bcd_corr[4*g +: 4])
        );
    end

    always_comb begin
        res_out = 8'h00;
        res_err = 1'b0;
        if (inv_q) begin
            res_out = 8'h00;
            res_err = 1'b1;
        end else if (!neg_q && (mag_q > 10'(MAG_MAX_POS))) begin
            res_out = 8'h7F;
            res_err = 1'b1;
        end else if (neg_q && (mag_q > 10'(MAG_MAX_NEG))) begin
            res_out = 8'h80;
            res_err = 1'b1;
        end else if (neg_q) begin
            // -128 falls out naturally: ~8'h80 + 1 wraps back to 8'h80.
            res_out = ~mag_q[7:0] + 8'd1;
        end else begin
            res_out = mag_q[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            bcd_q <= '0;
            mag_q <= '0;
            cnt_q <= '0;
            neg_q <= 1'b0;
            inv_q <= 1'b0;
            out   <= 8'h00;
            busy  <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bcd_q <= {centena, dezena, unidade};
                        neg_q <= negative;
                        inv_q <= bcd_invalid({centena, dezena, unidade});
                        mag_q <= '0;
                        cnt_q <= '0;
                        busy  <= 1'b1;
                        state <= S_CONV;
                    end
                end
                S_CONV: begin
                    bcd_q <= bcd_corr;
                    mag_q <= shifted[9:0];
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == LAST_ITER) begin
                        state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    out   <= res_out;
                    error <= res_err;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_bin.sv
// Self-checking bench for bcd_bin: directed handshake cases with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model built from decimal arithmetic.
module tb_bcd_bin;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       negative;
    logic [3:0] centena, dezena, unidade;
    logic [7:0] out;
    logic       busy, done, error;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    bcd_bin dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .negative(negative),
        .centena (centena),
        .dezena  (dezena),
        .unidade (unidade),
        .out     (out),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected {error, out} from the decimal value of the operand.
    function automatic logic [8:0] ref_conv(input logic neg, input logic [3:0] c,
                                            input logic [3:0] d, input logic [3:0] u);
        int v;
        if (c > 9 || d > 9 || u > 9) return {1'b1, 8'h00};
        v = int'(c) * 100 + int'(d) * 10 + int'(u);
        if (!neg) begin
            if (v > 127) return {1'b1, 8'h7F};
            return {1'b0, 8'(v)};
        end
        if (v > 128) return {1'b1, 8'h80};
        return {1'b0, 8'((256 - v) % 256)};
    endfunction

    // Cycle-level model: m_cnt counts cycles since an accepted start
    // (0 = idle); the result appears 11 edges after acceptance.
    int         m_cnt;
    logic       m_done;
    logic [7:0] m_out;
    logic       m_err;
    logic       m_neg;
    logic [3:0] m_c, m_d, m_u;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_out  <= 8'h00;
            m_err  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt != 0) begin
                if (m_cnt == 11) begin
                    m_cnt  <= 0;
                    m_done <= 1'b1;
                    {m_err, m_out} <= ref_conv(m_neg, m_c, m_d, m_u);
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end else if (start) begin
                m_cnt <= 1;
                m_neg <= negative;
                m_c   <= centena;
                m_d   <= dezena;
                m_u   <= unidade;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", busy, (m_cnt != 0));
            check("done", done, m_done);
            check("out", out, m_out);
            check("error", error, m_err);
        end
    end

    // Drive a conversion from a negedge and wait (bounded) for done.
    // Leaves time at the negedge where done is high.
    task automatic conv(input logic neg, input logic [3:0] c, input logic [3:0] d,
                        input logic [3:0] u, input logic [7:0] exp_out, input logic exp_err,
                        input string name);
        int lat;
        int bcy;
        negative = neg;
        centena  = c;
        dezena   = d;
        unidade  = u;
        start    = 1'b1;
        lat      = -1;
        bcy      = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (done) begin
                lat = i - 1;
                check({name, "_busy_at_done"}, busy, 1'b0);
                break;
            end
            if (busy) bcy++;
        end
        check({name, "_latency"}, lat, 11);
        check({name, "_busy_cycles"}, bcy, 11);
        check({name, "_out"}, out, exp_out);
        check({name, "_err"}, error, exp_err);
    endtask

    initial begin
        int ndone;
        rst_n    = 1'b0;
        start    = 1'b0;
        negative = 1'b0;
        centena  = 4'd0;
        dezena   = 4'd0;
        unidade  = 4'd0;

        // Pin the model against hand-worked values.
        check("model_127", ref_conv(1'b0, 4'd1, 4'd2, 4'd7), {1'b0, 8'h7F});
        check("model_m128", ref_conv(1'b1, 4'd1, 4'd2, 4'd8), {1'b0, 8'h80});
        check("model_m5", ref_conv(1'b1, 4'd0, 4'd0, 4'd5), {1'b0, 8'hFB});
        check("model_m129", ref_conv(1'b1, 4'd1, 4'd2, 4'd9), {1'b1, 8'h80});
        check("model_inv", ref_conv(1'b0, 4'd0, 4'd10, 4'd3), {1'b1, 8'h00});

        repeat (3) @(negedge clk);
        check("rst_out", out, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", error, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        cmp_en = 1'b1;

        conv(1'b0, 4'd1, 4'd2, 4'd7, 8'h7F, 1'b0, "p127");
        @(negedge clk);
        conv(1'b1, 4'd1, 4'd2, 4'd8, 8'h80, 1'b0, "m128");
        @(negedge clk);
        conv(1'b1, 4'd0, 4'd0, 4'd5, 8'hFB, 1'b0, "m5");
        @(negedge clk);
        conv(1'b1, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, "m0");
        @(negedge clk);
        conv(1'b0, 4'd2, 4'd0, 4'd0, 8'h7F, 1'b1, "p200");
        @(negedge clk);
        conv(1'b0, 4'd0, 4'd10, 4'd3, 8'h00, 1'b1, "inv");
        @(negedge clk);

        // Start pulsed mid-conversion must be ignored.
        negative = 1'b0; centena = 4'd0; dezena = 4'd5; unidade = 4'd0;
        start = 1'b1;
        ndone = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 4) begin
                negative = 1'b1; centena = 4'd9; dezena = 4'd9; unidade = 4'd9;
                start = 1'b1;
            end
            if (done) begin
                ndone++;
                check("hs1_out", out, 8'h32);
                check("hs1_err", error, 1'b0);
            end
        end
        check("hs1_done_count", ndone, 1);

        // Back-to-back: a start in the done cycle is accepted.
        conv(1'b0, 4'd0, 4'd1, 4'd9, 8'h13, 1'b0, "hs2a");
        conv(1'b0, 4'd0, 4'd4, 4'd2, 8'h2A, 1'b0, "hs2b");
        @(negedge clk);

        // Reset mid-conversion aborts without a done.
        negative = 1'b1; centena = 4'd0; dezena = 4'd6; unidade = 4'd4;
        start = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("hs3_busy_before", busy, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("hs3_out", out, 8'h00);
        check("hs3_busy", busy, 1'b0);
        check("hs3_done", done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("hs3_no_done", ndone, 0);
        conv(1'b0, 4'd0, 4'd9, 4'd9, 8'h63, 1'b0, "hs3_after");
        @(negedge clk);

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 4000; i++) begin
            start    = ($urandom_range(0, 3) == 0);
            negative = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                centena = 4'($urandom_range(0, 15));
                dezena  = 4'($urandom_range(0, 15));
                unidade = 4'($urandom_range(0, 15));
            end else begin
                centena = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 1))
                                                       : 4'($urandom_range(0, 9));
                dezena  = 4'($urandom_range(0, 9));
                unidade = 4'($urandom_range(0, 9));
            end
            @(negedge clk);
        end
        start = 1'b0;
        repeat (15) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
